// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the 1-D CNN layer blocks.
package cnn1d_pkg;

  // Serialiser FSM: waiting for a frame, or streaming a captured frame out word by word.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

  // Ceiling log2 with a floor of 1, so a counter for N >= 2 is never zero-width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/conv1d_layer_serialiser.sv
// Parallel-to-serial stage: captures one word per filter channel, then streams them out in channel order.
// Optional ser_last_out port is enabled with macro CNN1D_SERIALISER_LAST_EN.
module conv1d_layer_serialiser
  import cnn1d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_FILTERS = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 ser_ready_in,
  input  logic [NUM_FILTERS-1:0]               ser_valid_in,
  input  logic [DATA_WIDTH-1:0]                ser_data_in [0:NUM_FILTERS-1],
  input  logic                                 ser_ready_out,
  output logic                                 ser_valid_out,
  output logic [DATA_WIDTH-1:0]                ser_data_out,
  output logic [cnn1d_pkg::clog2(NUM_FILTERS)-1:0] ser_channel_out,
  output logic                                 ser_error
`ifdef CNN1D_SERIALISER_LAST_EN
  ,
  output logic                                 ser_last_out
`endif
);

  localparam int unsigned CH_W = cnn1d_pkg::clog2(NUM_FILTERS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_FILTERS - 1);

  ser_state_e              state_q, state_d;
  logic [CH_W-1:0]         chan_q, chan_d;
  logic                    error_q, error_d;
  logic [DATA_WIDTH-1:0]   buf_q [NUM_FILTERS];

  logic                    all_valid;
  logic                    partial_valid;
  logic                    capture;
  logic                    beat_done;
  logic                    last_beat;

  assign all_valid     = &ser_valid_in;
  assign partial_valid = (|ser_valid_in) && !all_valid;
  assign capture       = ser_ready_in && all_valid;
  assign beat_done     = ser_valid_out && ser_ready_out;
  assign last_beat     = beat_done && (chan_q == LAST_CH);

  // State, channel counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      chan_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      error_q <= error_d;
    end
  end

  // Frame buffer deliberately carries no reset; it is only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
        buf_q[i] <= ser_data_in[i];
      end
    end
  end

  // Next-state: a capture on the last beat restarts the stream at channel 0 without a bubble.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    error_d = error_q;
    if (ser_ready_in && partial_valid) begin
      error_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        chan_d = '0;
        if (capture) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (last_beat) begin
          chan_d  = '0;
          state_d = capture ? STREAM : IDLE;
        end else if (beat_done) begin
          chan_d = chan_q + CH_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        chan_d  = '0;
      end
    endcase
  end

  // Outputs: data/channel come straight from registers, so they hold under backpressure.
  always_comb begin
    ser_valid_out   = 1'b0;
    ser_ready_in    = 1'b0;
    ser_data_out    = buf_q[chan_q];
    ser_channel_out = chan_q;
    ser_error       = error_q;
    unique case (state_q)
      IDLE: begin
        ser_ready_in = !rst;
      end
      STREAM: begin
        ser_valid_out = 1'b1;
        ser_ready_in  = !rst && ser_ready_out && (chan_q == LAST_CH);
      end
      default: begin
        ser_valid_out = 1'b0;
        ser_ready_in  = 1'b0;
      end
    endcase
  end

`ifdef CNN1D_SERIALISER_LAST_EN
  assign ser_last_out = ser_valid_out && (chan_q == LAST_CH);
`endif

endmodule
